// File: rtl/keypad_pkg.sv
// Shared keypad types, constants and key-map helpers.
// Latency: pure combinational helpers, no state.
// Backpressure: none; used by the decoder and by the column sequencer bench.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kpd_state_t;

    localparam logic [3:0] KP_IDLE  = 4'b1111;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // True when exactly one line of an active-low bus is pulled low.
    function automatic logic one_low(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

    // Position of the low line; bit 3 is line 0 (4'b0111 = line 0).
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0111: idx = 2'd0;
            4'b1011: idx = 2'd1;
            4'b1101: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Physical key position to hex code.
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_HASH;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/kp_sync2.sv
// Two-flop synchronizer for an asynchronous bus, resets to all ones (idle).
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
module kp_sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back capture stages to settle metastability.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_decoder.sv
// Debounces one keypad press into a hex code with a strobe and a held-down level.
// Latency: strobe DEBOUNCE_CYCLES+2 edges after the inputs settle; kphit drops 3 edges after release.
// Backpressure: none; a new press is ignored until the previous release is debounced.
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] kpc,
    input  logic [3:0] kpr,
    output logic [3:0] key,
    output logic       key_strobe,
    output logic       kphit
);

    localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    kpc_s;
    logic [3:0]    kpr_s;
    logic          sample_vld;
    logic [3:0]    sample_code;
    kpd_state_t    state;
    logic [CW-1:0] cnt;
    logic [3:0]    cand;

    // Both buses use identical synchronizers so each row sample stays paired with its column.
    kp_sync2 #(.W(4)) u_sync_kpc (.clk(clk), .reset_n(reset_n), .d(kpc), .q(kpc_s));
    kp_sync2 #(.W(4)) u_sync_kpr (.clk(clk), .reset_n(reset_n), .d(kpr), .q(kpr_s));

    assign sample_vld  = one_low(kpc_s) && one_low(kpr_s);
    assign sample_code = key_lookup(low_index(kpr_s), low_index(kpc_s));

    // Press/release debounce FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cand       <= '0;
            key        <= '0;
            key_strobe <= 1'b0;
            kphit      <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_vld) begin
                        cand  <= sample_code;
                        cnt   <= CW'(1);
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (sample_vld && (sample_code == cand)) begin
                        if (cnt == TERM) begin
                            key        <= cand;
                            key_strobe <= 1'b1;
                            kphit      <= 1'b1;
                            state      <= PRESSED;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                PRESSED: begin
                    // A second key while held is ignored; only all-rows-idle starts release.
                    if (kpr_s == KP_IDLE) begin
                        kphit <= 1'b0;
                        cnt   <= CW'(1);
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (kpr_s != KP_IDLE) begin
                        cnt <= '0;
                    end else if (cnt == TERM) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
